// File: rtl/alpha_pixel_fetch.sv
// Alpha-blend read stage: walks a rectangle in raster order, issuing a source
// then a destination SRAM read per pixel and presenting the captured pair.
module alpha_pixel_fetch #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int COORD_W  = 10,
  parameter int FB_WIDTH = 640,
  parameter int MEM_LAT  = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic               fetch_req,
  output logic               mem_ren,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  src_pix,
  output logic [DATA_W-1:0]  dst_pix,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic               pix_valid,
  output logic               read_done,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, ARMED, ISSUE_S, ISSUE_D, WAIT_D, DONE} state_t;

  state_t                   state;
  logic [COORD_W-1:0]       x0_q, w_q, x, y;
  logic [ADDR_W-1:0]        src_base_q, dst_base_q;
  logic [2*COORD_W-1:0]     remaining;
  // Bit k is high in the k-th cycle after a read was issued; src_pipe tags it.
  logic [MEM_LAT:0]         vld_pipe, src_pipe;
  logic [ADDR_W-1:0]        pix_off;
  logic                     last_col;

  assign pix_off  = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
  assign last_col = (x - x0_q) == (w_q - COORD_W'(1));
  assign mem_ren  = vld_pipe[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      x0_q       <= '0;
      w_q        <= '0;
      x          <= '0;
      y          <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      remaining  <= '0;
      vld_pipe   <= '0;
      src_pipe   <= '0;
      mem_addr   <= '0;
      src_pix    <= '0;
      dst_pix    <= '0;
      pix_addr   <= '0;
      pix_valid  <= 1'b0;
      read_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[MEM_LAT-1:0], 1'b0};
      src_pipe <= {src_pipe[MEM_LAT-1:0], 1'b0};
      if (vld_pipe[MEM_LAT]) begin
        if (src_pipe[MEM_LAT]) src_pix <= mem_rdata;
        else                   dst_pix <= mem_rdata;
      end
      case (state)
        IDLE, DONE: if (start) begin
          x0_q       <= x0;
          w_q        <= w;
          x          <= x0;
          y          <= y0;
          src_base_q <= src_base;
          dst_base_q <= dst_base;
          remaining  <= (2*COORD_W)'(w) * (2*COORD_W)'(h);
          pix_valid  <= 1'b0;
          read_done  <= 1'b0;
          busy       <= 1'b1;
          state      <= ARMED;
        end
        ARMED: if (fetch_req) begin
          if (remaining == '0) begin
            read_done <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            pix_valid   <= 1'b0;
            vld_pipe[0] <= 1'b1;
            src_pipe[0] <= 1'b1;
            mem_addr    <= src_base_q + pix_off;
            state       <= ISSUE_S;
          end
        end
        ISSUE_S: begin
          vld_pipe[0] <= 1'b1;
          mem_addr    <= dst_base_q + pix_off;
          state       <= ISSUE_D;
        end
        ISSUE_D: begin
          pix_addr  <= mem_addr;
          remaining <= remaining - 1'b1;
          if (last_col) begin
            x <= x0_q;
            y <= y + COORD_W'(1);
          end else begin
            x <= x + COORD_W'(1);
          end
          state <= WAIT_D;
        end
        WAIT_D: if (vld_pipe[MEM_LAT] && !src_pipe[MEM_LAT]) begin
          // dst data lands this edge; the pair is complete from the next cycle
          pix_valid <= 1'b1;
          state     <= ARMED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_pixel_fetch.sv
// Bench for alpha_pixel_fetch: table of rectangles plus hand sequences for
// reset abort, ignored pulses and address wrap.
`timescale 1ns/1ps
module tb_alpha_pixel_fetch;
  localparam int ADDR_W = 20, DATA_W = 32, COORD_W = 10;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               start, fetch_req;
  logic [COORD_W-1:0] x0, y0, w, h;
  logic [ADDR_W-1:0]  src_base, dst_base;
  logic               mem_ren;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_rdata;
  logic [DATA_W-1:0]  src_pix, dst_pix;
  logic [ADDR_W-1:0]  pix_addr;
  logic               pix_valid, read_done, busy;

  alpha_pixel_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COORD_W(COORD_W),
                      .FB_WIDTH(640), .MEM_LAT(2)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .src_base(src_base), .dst_base(dst_base), .fetch_req(fetch_req),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .src_pix(src_pix), .dst_pix(dst_pix), .pix_addr(pix_addr),
    .pix_valid(pix_valid), .read_done(read_done), .busy(busy));

  always #5 clk = ~clk;

  // SRAM model: two-cycle latency, content is a function of the address
  function automatic logic [31:0] mem_f(input logic [19:0] a);
    return {~a[11:0], a};
  endfunction
  logic [31:0] mp1 = '0, mp2 = '0;
  always @(posedge clk) begin
    mp1 <= mem_f(mem_addr);
    mp2 <= mp1;
  end
  assign mem_rdata = mp2;

  int ren_cnt = 0;
  always @(posedge clk) if (mem_ren) ren_cnt <= ren_cnt + 1;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [19:0] addr;
  } pair_t;
  pair_t sb_q[$];

  typedef struct {
    logic [9:0]  x0, y0, w, h;
    logic [19:0] sb, db;
    int          npix;
    logic [19:0] first_src;
  } vec_t;
  vec_t vt[5];

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [19:0] maddr(input logic [19:0] base, input int x, input int y);
    return 20'(int'(base) + y * 640 + x);
  endfunction

  task automatic do_start(input logic [9:0] ax0, ay0, aw, ah, input logic [19:0] sb, db);
    x0 = ax0; y0 = ay0; w = aw; h = ah; src_base = sb; dst_base = db;
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic fetch_pixel(input logic [19:0] sa, da, input string tag);
    pair_t p;
    int lat;
    sb_q.push_back('{mem_f(sa), mem_f(da), da});
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    chk({tag, " src_ren"}, mem_ren, 1);
    chk({tag, " src_addr"}, mem_addr, sa);
    step();
    chk({tag, " dst_ren"}, mem_ren, 1);
    chk({tag, " dst_addr"}, mem_addr, da);
    lat = 1;
    while (!pix_valid && lat < 12) begin step(); lat++; end
    chk({tag, " latency"}, lat, 4);
    if (sb_q.size() > 0) begin
      p = sb_q.pop_front();
      chk({tag, " src_pix"}, src_pix, p.src);
      chk({tag, " dst_pix"}, dst_pix, p.dst);
      chk({tag, " pix_addr"}, pix_addr, p.addr);
    end
  endtask

  task automatic fetch_end(input string tag);
    int r0;
    r0 = ren_cnt;
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    chk({tag, " read_done"}, read_done, 1);
    chk({tag, " busy_done"}, busy, 0);
    step();
    chk({tag, " no_ren"}, ren_cnt - r0, 0);
    chk({tag, " done_hold"}, read_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, n;
    bit bad;
    pair_t p;

    vt[0] = '{10'd2,    10'd1, 10'd1, 10'd1, 20'h10000, 20'h20000, 1, 20'h10282};
    vt[1] = '{10'd638,  10'd0, 10'd3, 10'd2, 20'h10000, 20'h20000, 6, 20'h1027E};
    vt[2] = '{10'd0,    10'd0, 10'd0, 10'd5, 20'h10000, 20'h20000, 0, 20'h00000};
    vt[3] = '{10'd5,    10'd3, 10'd2, 10'd0, 20'h10000, 20'h20000, 0, 20'h00000};
    vt[4] = '{10'd1020, 10'd2, 10'd4, 10'd2, 20'hFFC00, 20'h00100, 8, 20'h004FC};

    n_rst = 1'b0; start = 1'b0; fetch_req = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; src_base = '0; dst_base = '0;
    #2;
    chk("rst mem_ren", mem_ren, 0);
    chk("rst outputs", {mem_addr, src_pix, dst_pix, pix_addr, pix_valid, read_done, busy}, 0);
    step(); step();
    n_rst = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      do_start(vt[v].x0, vt[v].y0, vt[v].w, vt[v].h, vt[v].sb, vt[v].db);
      chk($sformatf("v%0d busy", v), busy, 1);
      chk($sformatf("v%0d done_clr", v), read_done, 0);
      r0 = ren_cnt;
      n = 0;
      for (int yy = 0; yy < int'(vt[v].h); yy++)
        for (int xx = 0; xx < int'(vt[v].w); xx++) begin
          if (n == 0)
            chk($sformatf("v%0d first_src", v),
                maddr(vt[v].sb, vt[v].x0 + xx, vt[v].y0 + yy), vt[v].first_src);
          fetch_pixel(maddr(vt[v].sb, vt[v].x0 + xx, vt[v].y0 + yy),
                      maddr(vt[v].db, vt[v].x0 + xx, vt[v].y0 + yy),
                      $sformatf("v%0d p%0d", v, n));
          n++;
        end
      chk($sformatf("v%0d ren_count", v), ren_cnt - r0, 2 * vt[v].npix);
      fetch_end($sformatf("v%0d", v));
    end

    // Reset during ISSUE_D aborts; afterwards fetch_req does nothing until start
    do_start(10'd638, 10'd0, 10'd3, 10'd2, 20'h10000, 20'h20000);
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    step();
    chk("rst_mid in ISSUE_D", mem_ren, 1);
    #1 n_rst = 1'b0;
    #1;
    chk("rst_mid mem_ren", mem_ren, 0);
    chk("rst_mid outputs", {mem_addr, src_pix, dst_pix, pix_addr, pix_valid, read_done, busy}, 0);
    step(); n_rst = 1'b1; step();
    r0 = ren_cnt;
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pix_valid || busy || read_done) bad = 1'b1;
      step();
    end
    chk("rst_mid ignore_ren", ren_cnt - r0, 0);
    chk("rst_mid ignore_out", bad, 0);

    // Stray fetch_req in ISSUE_S and start in WAIT_D; src address wraps to 0
    do_start(10'd1, 10'd0, 10'd1, 10'd1, 20'hFFFFF, 20'h00010);
    r0 = ren_cnt;
    sb_q.push_back('{mem_f(20'h00000), mem_f(20'h00011), 20'h00011});
    fetch_req = 1'b1; step();
    chk("ign src_wrap", mem_addr, 20'h00000);
    step(); fetch_req = 1'b0;
    chk("ign dst_addr", mem_addr, 20'h00011);
    step();
    x0 = 10'd0; y0 = 10'd0; w = 10'd4; h = 10'd4; start = 1'b1;
    step(); start = 1'b0;
    chk("ign not_yet", pix_valid, 0);
    step();
    chk("ign pix_valid", pix_valid, 1);
    if (sb_q.size() > 0) begin
      p = sb_q.pop_front();
      chk("ign src_pix", src_pix, p.src);
      chk("ign dst_pix", dst_pix, p.dst);
      chk("ign pix_addr", pix_addr, p.addr);
    end
    chk("ign ren_count", ren_cnt - r0, 2);
    fetch_end("ign");
    chk("ign pix_hold", pix_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
